// File: rtl/load_store_unit.sv
// Load/store unit: IDLE -> REQ -> DONE access FSM with byte-lane steering, load extension and a REQ watchdog.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses skip memory and raise misaligned.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        result_valid,
    output logic [31:0] rdata_out,
    output logic        misaligned,
    output logic        timeout,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [1:0]  state_dbg
);
    // Handshake: dmem_req/we/addr/be/wdata are held while in REQ; a cycle with dmem_ack=1 completes it.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2} state_t;

    localparam logic [1:0] SZ_B    = 2'd0;
    localparam logic [1:0] SZ_H    = 2'd1;
    localparam logic [1:0] SZ_W    = 2'd2;
    localparam logic [7:0] WD_LAST = 8'd254;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        load_q, load_d;
    logic        to_q, to_d;
    logic [7:0]  wd_q, wd_d;
    logic [1:0]  in_size;
    logic        accept;
    logic        trap;
    logic [1:0]  off;
    logic [31:0] shifted;
    logic [31:0] load_val;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        mis_q, mis_d;
`endif

    // Unsupported encodings 011/110/111 collapse onto word size.
    assign in_size = (funct3[1:0] == 2'b11) ? SZ_W : funct3[1:0];
    assign accept  = (state_q == S_IDLE) & in_valid & (mem_read | mem_write);

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = ((in_size == SZ_H) & addr[0]) | ((in_size == SZ_W) & (addr[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        off = 2'b00;
        case (size_q)
            SZ_B:    off = addr_q[1:0];
            SZ_H:    off = {addr_q[1], 1'b0};
            default: off = 2'b00;
        endcase
    end

    assign shifted = dmem_rdata >> {off, 3'b000};

    always_comb begin
        load_val = shifted;
        case (size_q)
            SZ_B:    load_val = uns_q ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H:    load_val = uns_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = trap ? S_DONE : S_REQ;
            S_REQ:  if (dmem_ack || (wd_q == WD_LAST)) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            load_q  <= 1'b0;
            to_q    <= 1'b0;
            wd_q    <= '0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            load_q  <= load_d;
            to_q    <= to_d;
            wd_q    <= wd_d;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) mis_q <= 1'b0;
        else       mis_q <= mis_d;
    end
`endif

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        load_d  = load_q;
        to_d    = to_q;
        wd_d    = wd_q;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_d   = mis_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    size_d  = in_size;
                    uns_d   = funct3[2];
                    load_d  = mem_read;
                    wd_d    = '0;
                    to_d    = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                    mis_d   = trap;
`endif
                    if (trap) rdata_d = '0;
                end
            end
            S_REQ: begin
                if (dmem_ack) begin
                    rdata_d = load_q ? load_val : 32'b0;
                    to_d    = 1'b0;
                end else begin
                    wd_d = wd_q + 8'd1;
                    // The 255th unacknowledged REQ cycle is the last one.
                    if (wd_q == WD_LAST) begin
                        rdata_d = '0;
                        to_d    = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        stall        = (state_q != S_IDLE) | accept;
        result_valid = (state_q == S_DONE);
        rdata_out    = rdata_q;
        timeout      = to_q & (state_q == S_DONE);
        state_dbg    = state_q;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        dmem_addr    = '0;
        dmem_wdata   = '0;
        dmem_be      = '0;
        if (state_q == S_REQ) begin
            dmem_req  = 1'b1;
            dmem_we   = ~load_q;
            dmem_addr = {addr_q[31:2], 2'b00};
            case (size_q)
                SZ_B: begin
                    dmem_be    = 4'b0001 << off;
                    dmem_wdata = {4{wdata_q[7:0]}};
                end
                SZ_H: begin
                    dmem_be    = 4'b0011 << off;
                    dmem_wdata = {2{wdata_q[15:0]}};
                end
                default: begin
                    dmem_be    = 4'b1111;
                    dmem_wdata = wdata_q;
                end
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = mis_q & (state_q == S_DONE);
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-level reference model of lane selection and extension.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, result_valid, misaligned, timeout;
    logic [31:0] rdata_out;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic [1:0]  state_dbg;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_q[$];

    logic        r_ld, r_wr;
    logic [2:0]  r_f3;
    int          r_k;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .result_valid(result_valid),
        .rdata_out(rdata_out), .misaligned(misaligned), .timeout(timeout), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .state_dbg(state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    // First byte of the access inside the word, with low bits dropped to natural alignment.
    function automatic int lane_off(input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = nbytes(f3);
        return (int'(a[1:0]) / n) * n;
    endfunction

    function automatic bit is_trapped(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return (int'(a[1:0]) % nbytes(f3)) != 0;
`else
        return (a[1:0] == 2'b00) && (f3 == 3'b111) && (a[0] != a[0]);
`endif
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
        longint v;
        int     n, o;
        n = nbytes(f3);
        o = lane_off(f3, a);
        v = 0;
        for (int i = 0; i < n; i++) v = v | (longint'(word[8*(o+i) +: 8]) << (8*i));
        if ((f3 == 3'b000 || f3 == 3'b001) && v[8*n-1]) v = v - (longint'(1) << (8*n));
        return v[31:0];
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] be;
        int         n, o;
        n = nbytes(f3);
        o = lane_off(f3, a);
        be = '0;
        for (int i = 0; i < n; i++) be[o+i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] w;
        int          n;
        n = nbytes(f3);
        for (int j = 0; j < 4; j++) w[8*j +: 8] = wd[8*(j % n) +: 8];
        return w;
    endfunction

    // Entered and left at posedge+1 with the DUT idle and in_valid low.
    task automatic access(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word, input int ack_dly);
        bit          trapped, exp_to, got;
        int          exp_lat, lat, bad, nreq, exp_nreq;
        logic [31:0] exp_rd, exp_a, exp_w;
        logic [3:0]  be;
        trapped  = is_trapped(f3, a);
        exp_to   = !trapped && (ack_dly >= 255);
        exp_rd   = (trapped || exp_to || !rd) ? 32'b0 : exp_load(f3, a, word);
        exp_lat  = trapped ? 1 : (exp_to ? 256 : ack_dly + 2);
        exp_nreq = trapped ? 0 : (exp_to ? 255 : ack_dly + 1);
        exp_a    = {a[31:2], 2'b00};
        be       = exp_be(f3, a);
        exp_w    = exp_wd(f3, wd);
        exp_q.push_back(exp_rd);

        in_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        #1;
        check({name, "/stall_acc"}, 32'(stall), 32'd1);
        check({name, "/req_acc"}, 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; mem_read = 1'($urandom_range(0, 1)); mem_write = 1'($urandom_range(0, 1));
        funct3 = 3'($urandom_range(0, 7)); addr = $urandom; wdata = $urandom;

        got = 0; bad = 0; nreq = 0; lat = 0;
        for (int c = 1; c <= 300 && !got; c++) begin
            if (result_valid) begin
                got = 1;
                lat = c;
            end else begin
                if (dmem_req !== 1'b1 || stall !== 1'b1) bad++;
                else begin
                    if (nreq == 0) begin
                        check({name, "/dmem_addr"}, dmem_addr, exp_a);
                        check({name, "/dmem_be"}, 32'(dmem_be), 32'(be));
                        check({name, "/dmem_we"}, 32'(dmem_we), 32'(!rd));
                        if (!rd) check({name, "/dmem_wdata"}, dmem_wdata, exp_w);
                    end else if (dmem_addr !== exp_a || dmem_be !== be || dmem_we !== !rd ||
                                 (!rd && dmem_wdata !== exp_w)) bad++;
                    if (nreq == ack_dly) begin
                        dmem_ack = 1'b1; dmem_rdata = word;
                    end else begin
                        dmem_ack = 1'b0; dmem_rdata = $urandom;
                    end
                    nreq++;
                end
                @(posedge clk); #1;
                dmem_ack = 1'b0;
            end
        end

        check({name, "/done_seen"}, 32'(got), 32'd1);
        check({name, "/latency"}, 32'(lat), 32'(exp_lat));
        check({name, "/req_cycles"}, 32'(nreq), 32'(exp_nreq));
        check({name, "/req_hold"}, 32'(bad), 32'd0);
        check({name, "/rdata_out"}, rdata_out, exp_q.pop_front());
        check({name, "/timeout"}, 32'(timeout), 32'(exp_to));
        check({name, "/misaligned"}, 32'(misaligned), 32'(trapped));
        check({name, "/req_in_done"}, 32'(dmem_req), 32'd0);

        // Late ack while returning to idle must not disturb anything.
        dmem_ack = 1'b1; dmem_rdata = $urandom;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        check({name, "/rv_pulse"}, 32'(result_valid), 32'd0);
        check({name, "/rdata_hold"}, rdata_out, exp_rd);
        check({name, "/stall_idle"}, 32'(stall), 32'd0);
        check({name, "/req_idle"}, 32'(dmem_req), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, required finish before 2 ms");
        $fatal(1, "bench time limit");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0;
        addr = '0; wdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst/stall", 32'(stall), 32'd0);
        check("rst/result_valid", 32'(result_valid), 32'd0);
        check("rst/rdata_out", rdata_out, 32'd0);
        check("rst/misaligned", 32'(misaligned), 32'd0);
        check("rst/timeout", 32'(timeout), 32'd0);
        check("rst/dmem_req", 32'(dmem_req), 32'd0);
        check("rst/dmem_we", 32'(dmem_we), 32'd0);
        check("rst/dmem_be", 32'(dmem_be), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // in_valid with no memory flag is ignored.
        in_valid = 1'b1;
        #1;
        check("noflag/stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        check("noflag/dmem_req", 32'(dmem_req), 32'd0);
        check("noflag/result_valid", 32'(result_valid), 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("noflag/result_valid2", 32'(result_valid), 32'd0);

        access("lw",      1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,          32'hDEAD_BEEF, 0);
        access("lb",      1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,          32'h80FF_FF00, 0);
        access("lbu",     1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,          32'h80FF_FF00, 1);
        access("lhu",     1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,          32'h80FF_FF00, 0);
        access("lh",      1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,          32'h80FF_FF00, 2);
        access("sb",      1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h1234_5678,  32'hFFFF_FFFF, 0);
        access("sh",      1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_5678,  32'hFFFF_FFFF, 1);
        access("lw_dly5", 1'b1, 1'b0, 3'b010, 32'h0000_0180, 32'h0,          32'h0BAD_F00D, 5);
        access("ld_rw",   1'b1, 1'b1, 3'b010, 32'h0000_0184, 32'h5555_5555,  32'h1357_9BDF, 0);
        access("lw_f011", 1'b1, 1'b0, 3'b011, 32'h0000_0188, 32'h0,          32'hA5A5_0F0F, 0);
        access("sw_302",  1'b0, 1'b1, 3'b010, 32'h0000_0302, 32'hCAFE_BABE,  32'h0,         0);
        access("lh_101",  1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0,          32'h1234_8765, 0);
        access("lw_tmo",  1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0,          32'h1111_2222, 1000);

        // Reset during REQ aborts the access; a following ack is ignored.
        in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_0500;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("abort/req_before", 32'(dmem_req), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort/dmem_req", 32'(dmem_req), 32'd0);
        check("abort/result_valid", 32'(result_valid), 32'd0);
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort/late_rv", 32'(result_valid), 32'd0);
            check("abort/late_req", 32'(dmem_req), 32'd0);
            check("abort/late_rdata", rdata_out, 32'd0);
        end
        dmem_ack = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 40; t++) begin
            r_ld = 1'($urandom_range(0, 1));
            if (r_ld) begin
                r_f3 = 3'($urandom_range(0, 7));
                r_wr = 1'($urandom_range(0, 1));
            end else begin
                r_k  = $urandom_range(0, 4);
                r_f3 = (r_k == 0) ? 3'b000 : (r_k == 1) ? 3'b001 : (r_k == 2) ? 3'b010 :
                       (r_k == 3) ? 3'b011 : 3'b110;
                r_wr = 1'b1;
            end
            access("rnd", r_ld, r_wr, r_f3, $urandom, $urandom, $urandom, $urandom_range(0, 6));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
